// File: rtl/alu_rr_arbiter_if.sv
// Per-requester channel to the shared-ALU arbiter: a request (a, b, op) and a response (result, zero, err),
// each with its own valid/ready handshake.
interface alu_rr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_zero;
  logic              resp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE -> EXEC -> RESP, one operation at a time.
// Define ALU_OPCHECK_EN to answer opcodes above SLT locally (err=1) without using the ALU.
module alu_rr_arbiter #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  alu_rr_arbiter_if.slave   port0,
  alu_rr_arbiter_if.slave   port1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_reg, state_next;
  logic              rr_ptr_reg;
  logic              port_reg;
  logic [DATA_W-1:0] result_reg;
  logic              zero_reg;
  logic              err_reg;

  logic [1:0]        req_valid;
  logic [1:0]        resp_ready;
  logic [DATA_W-1:0] req_a [2];
  logic [DATA_W-1:0] req_b [2];
  logic [OP_W-1:0]   req_op [2];

  logic [1:0]        req_ready_vec;
  logic [1:0]        resp_valid_vec;
  logic [1:0]        resp_zero_vec;
  logic [1:0]        resp_err_vec;
  logic [DATA_W-1:0] resp_result_arr [2];

  logic              grant_port;
  logic              accept;
  logic              op_illegal;
  logic              resp_take;

  assign req_valid  = {port1.req_valid, port0.req_valid};
  assign resp_ready = {port1.resp_ready, port0.resp_ready};
  assign req_a[0]   = port0.req_a;
  assign req_a[1]   = port1.req_a;
  assign req_b[0]   = port0.req_b;
  assign req_b[1]   = port1.req_b;
  assign req_op[0]  = port0.req_op;
  assign req_op[1]  = port1.req_op;

  always_comb begin
    grant_port = 1'b0;
    if (req_valid == 2'b10) begin
      grant_port = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant_port = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr_reg;
    end
  end

  // rst gates ready so no handshake can be advertised while reset is held
  assign accept    = (state_reg == IDLE) && (|req_valid) && !rst;
  assign resp_take = (state_reg == RESP) && resp_ready[port_reg];

`ifdef ALU_OPCHECK_EN
  assign op_illegal = (req_op[grant_port] > OP_W'(8));
`else
  assign op_illegal = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = op_illegal ? RESP : EXEC;
      EXEC: state_next = RESP;
      RESP: if (resp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 1'b0;
      port_reg   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        port_reg <= grant_port;
        if (op_illegal) begin
          // ALU operands are left untouched; the answer is produced here
          result_reg <= '0;
          zero_reg   <= 1'b1;
          err_reg    <= 1'b1;
        end else begin
          alu_a    <= req_a[grant_port];
          alu_b    <= req_b[grant_port];
          alu_ctrl <= req_op[grant_port];
          err_reg  <= 1'b0;
        end
      end
      if (state_reg == EXEC) begin
        result_reg <= alu_result;
        zero_reg   <= alu_zero;
      end
      if (resp_take && (FIXED_PRIO == 0)) begin
        rr_ptr_reg <= ~port_reg;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready_vec[gi]   = accept && (grant_port == 1'(gi));
    assign resp_valid_vec[gi]  = (state_reg == RESP) && (port_reg == 1'(gi));
    assign resp_result_arr[gi] = resp_valid_vec[gi] ? result_reg : '0;
    assign resp_zero_vec[gi]   = resp_valid_vec[gi] && zero_reg;
    assign resp_err_vec[gi]    = resp_valid_vec[gi] && err_reg;
  end

  assign port0.req_ready   = req_ready_vec[0];
  assign port1.req_ready   = req_ready_vec[1];
  assign port0.resp_valid  = resp_valid_vec[0];
  assign port1.resp_valid  = resp_valid_vec[1];
  assign port0.resp_result = resp_result_arr[0];
  assign port1.resp_result = resp_result_arr[1];
  assign port0.resp_zero   = resp_zero_vec[0];
  assign port1.resp_zero   = resp_zero_vec[1];
  assign port0.resp_err    = resp_err_vec[0];
  assign port1.resp_err    = resp_err_vec[1];

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: a round-robin instance plus a FIXED_PRIO=1 instance fed the same stimulus.
module tb_alu_rr_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.DATA_W(DW), .OP_W(OW)) p0 ();
  alu_rr_arbiter_if #(.DATA_W(DW), .OP_W(OW)) p1 ();
  alu_rr_arbiter_if #(.DATA_W(DW), .OP_W(OW)) f0 ();
  alu_rr_arbiter_if #(.DATA_W(DW), .OP_W(OW)) f1 ();

  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_ctrl;
  logic          alu_zero, busy;
  logic [DW-1:0] fa, fb, fres;
  logic [OW-1:0] fctrl;
  logic          fzero, fbusy;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b[4:0];
      4'h6: return a >> b[4:0];
      4'h7: return $signed(a) >>> b[4:0];
      4'h8: return {31'd0, ($signed(a) < $signed(b))};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == 32'd0);
  assign fres       = alu_f(fa, fb, fctrl);
  assign fzero      = (fres == 32'd0);

  assign f0.req_valid  = p0.req_valid;
  assign f0.req_a      = p0.req_a;
  assign f0.req_b      = p0.req_b;
  assign f0.req_op     = p0.req_op;
  assign f0.resp_ready = p0.resp_ready;
  assign f1.req_valid  = p1.req_valid;
  assign f1.req_a      = p1.req_a;
  assign f1.req_b      = p1.req_b;
  assign f1.req_op     = p1.req_op;
  assign f1.resp_ready = p1.resp_ready;

  alu_rr_arbiter #(.DATA_W(DW), .OP_W(OW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .port0(p0), .port1(p1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  alu_rr_arbiter #(.DATA_W(DW), .OP_W(OW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .port0(f0), .port1(f1),
    .alu_a(fa), .alu_b(fb), .alu_ctrl(fctrl),
    .alu_result(fres), .alu_zero(fzero), .busy(fbusy)
  );

  int checks = 0;
  int errors = 0;
  int fp_g0 = 0;
  int fp_g1 = 0;
  logic fp_en = 1'b0;

  always @(posedge clk) begin
    if (fp_en) begin
      if (f0.req_valid && f0.req_ready) fp_g0++;
      if (f1.req_valid && f1.req_ready) fp_g1++;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    p0.req_valid = 1'b1; p0.req_a = '0; p0.req_b = '0; p0.req_op = '0; p0.resp_ready = 1'b0;
    p1.req_valid = 1'b0; p1.req_a = '0; p1.req_b = '0; p1.req_op = '0; p1.resp_ready = 1'b0;

    // reset state, with a request already pending on port 0
    @(negedge clk);
    chk1("rst_ready0", p0.req_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_alu_a", alu_a, 32'd0);
    chk32("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk1("rst_resp0_valid", p0.resp_valid, 1'b0);
    rst = 1'b0;
    p0.req_valid = 1'b0;
    @(negedge clk);

    // port 0 ADD 10+5
    p0.req_valid = 1'b1; p0.req_a = 32'd10; p0.req_b = 32'd5; p0.req_op = 4'h0;
    p0.resp_ready = 1'b1; p1.resp_ready = 1'b1;
    #1;
    chk1("add_ready0", p0.req_ready, 1'b1);
    chk1("add_ready1", p1.req_ready, 1'b0);
    @(negedge clk);
    p0.req_valid = 1'b0;
    chk1("add_exec_busy", busy, 1'b1);
    chk32("add_alu_a", alu_a, 32'd10);
    chk32("add_alu_b", alu_b, 32'd5);
    chk1("add_exec_resp0_valid", p0.resp_valid, 1'b0);
    @(negedge clk);
    chk1("add_resp0_valid", p0.resp_valid, 1'b1);
    chk32("add_result", p0.resp_result, 32'd15);
    chk1("add_zero", p0.resp_zero, 1'b0);
    chk1("add_err", p0.resp_err, 1'b0);
    chk1("add_resp1_valid", p1.resp_valid, 1'b0);
    @(negedge clk);
    chk1("add_done_valid", p0.resp_valid, 1'b0);
    chk1("add_done_busy", busy, 1'b0);

    // port 1 SUB 10-10
    p1.req_valid = 1'b1; p1.req_a = 32'd10; p1.req_b = 32'd10; p1.req_op = 4'h1;
    #1;
    chk1("sub_ready1", p1.req_ready, 1'b1);
    chk1("sub_ready0", p0.req_ready, 1'b0);
    @(negedge clk);
    p1.req_valid = 1'b0;
    chk32("sub_alu_ctrl", 32'(alu_ctrl), 32'd1);
    @(negedge clk);
    chk1("sub_resp1_valid", p1.resp_valid, 1'b1);
    chk32("sub_result", p1.resp_result, 32'd0);
    chk1("sub_zero", p1.resp_zero, 1'b1);
    chk1("sub_resp0_valid", p0.resp_valid, 1'b0);
    @(negedge clk);

    // both ports valid continuously: grants alternate 0,1,0,1
    p0.req_valid = 1'b1; p0.req_a = 32'd1; p0.req_b = 32'd4; p0.req_op = 4'h5;
    p1.req_valid = 1'b1; p1.req_a = 32'hFFFF_FFF8; p1.req_b = 32'd1; p1.req_op = 4'h7;
    fp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1($sformatf("alt%0d_ready0", i), p0.req_ready, (i % 2) == 0);
      chk1($sformatf("alt%0d_ready1", i), p1.req_ready, (i % 2) == 1);
      @(negedge clk);
      @(negedge clk);
      if ((i % 2) == 0) begin
        chk1($sformatf("alt%0d_resp0_valid", i), p0.resp_valid, 1'b1);
        chk32($sformatf("alt%0d_result0", i), p0.resp_result, 32'h0000_0010);
        chk1($sformatf("alt%0d_resp1_valid", i), p1.resp_valid, 1'b0);
      end else begin
        chk1($sformatf("alt%0d_resp1_valid", i), p1.resp_valid, 1'b1);
        chk32($sformatf("alt%0d_result1", i), p1.resp_result, 32'hFFFF_FFFC);
        chk1($sformatf("alt%0d_resp0_valid", i), p0.resp_valid, 1'b0);
      end
      @(negedge clk);
    end
    fp_en = 1'b0;
    p0.req_valid = 1'b0; p1.req_valid = 1'b0;
    chk32("fixed_prio_grants0", 32'(fp_g0), 32'd4);
    chk32("fixed_prio_grants1", 32'(fp_g1), 32'd0);

    // backpressure: port 0 SLT 3<5 held while port 1 waits
    p0.req_valid = 1'b1; p0.req_a = 32'd3; p0.req_b = 32'd5; p0.req_op = 4'h8; p0.resp_ready = 1'b0;
    p1.req_valid = 1'b1; p1.req_a = 32'd1; p1.req_b = 32'd2; p1.req_op = 4'h0;
    #1;
    chk1("bp_ready0", p0.req_ready, 1'b1);
    chk1("bp_ready1", p1.req_ready, 1'b0);
    @(negedge clk);
    p0.req_valid = 1'b0;
    chk1("bp_exec_ready1", p1.req_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1($sformatf("bp%0d_resp0_valid", i), p0.resp_valid, 1'b1);
      chk32($sformatf("bp%0d_result0", i), p0.resp_result, 32'd1);
      chk1($sformatf("bp%0d_ready1", i), p1.req_ready, 1'b0);
    end
    p0.resp_ready = 1'b1;
    @(negedge clk);
    chk1("bp_taken_valid0", p0.resp_valid, 1'b0);
    chk1("bp_ready1_after", p1.req_ready, 1'b1);
    @(negedge clk);
    p1.req_valid = 1'b0;
    @(negedge clk);
    chk1("bp_resp1_valid", p1.resp_valid, 1'b1);
    chk32("bp_result1", p1.resp_result, 32'd3);
    @(negedge clk);

    // undefined opcode 1111
    p0.req_valid = 1'b1; p0.req_a = 32'd7; p0.req_b = 32'd9; p0.req_op = 4'hF;
    #1;
    chk1("bad_ready0", p0.req_ready, 1'b1);
    @(negedge clk);
    p0.req_valid = 1'b0;
`ifdef ALU_OPCHECK_EN
    chk1("bad_resp0_valid", p0.resp_valid, 1'b1);
    chk32("bad_result", p0.resp_result, 32'd0);
    chk1("bad_zero", p0.resp_zero, 1'b1);
    chk1("bad_err", p0.resp_err, 1'b1);
    chk32("bad_alu_ctrl_kept", 32'(alu_ctrl), 32'd0);
    chk32("bad_alu_a_kept", alu_a, 32'd1);
    @(negedge clk);
`else
    chk32("bad_alu_ctrl", 32'(alu_ctrl), 32'hF);
    chk1("bad_exec_valid", p0.resp_valid, 1'b0);
    @(negedge clk);
    chk1("bad_resp0_valid", p0.resp_valid, 1'b1);
    chk32("bad_result", p0.resp_result, 32'd0);
    chk1("bad_zero", p0.resp_zero, 1'b1);
    chk1("bad_err", p0.resp_err, 1'b0);
    @(negedge clk);
`endif
    chk1("bad_done_busy", busy, 1'b0);

    // reset during EXEC of a port 1 transaction
    p0.req_valid = 1'b1; p0.req_a = 32'd4; p0.req_b = 32'd4; p0.req_op = 4'h0;
    p1.req_valid = 1'b1; p1.req_a = 32'd2; p1.req_b = 32'd3; p1.req_op = 4'h0;
    #1;
    chk1("rr_ready1", p1.req_ready, 1'b1);
    chk1("rr_ready0", p0.req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk32("arst_alu_a", alu_a, 32'd0);
    chk32("arst_alu_b", alu_b, 32'd0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_resp1_valid", p1.resp_valid, 1'b0);
    chk1("arst_ready0", p0.req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("post_rst_ready0", p0.req_ready, 1'b1);
    chk1("post_rst_ready1", p1.req_ready, 1'b0);
    @(negedge clk);
    p0.req_valid = 1'b0; p1.req_valid = 1'b0;
    chk1("post_rst_exec_resp1", p1.resp_valid, 1'b0);
    @(negedge clk);
    chk1("post_rst_resp0_valid", p0.resp_valid, 1'b1);
    chk32("post_rst_result0", p0.resp_result, 32'd8);
    chk1("post_rst_resp1_valid", p1.resp_valid, 1'b0);
    @(negedge clk);
    chk1("post_rst_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
